// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the EX-stage divide sequencer: state encoding and
// the fill value used for the quotient half of a divide-by-zero result.
package div_sequencer_pkg;

  // Two-bit state encoding, also exported on the debug port.
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_BUSY = 2'd1,
    DS_DONE = 2'd2
  } ds_state_t;

  // Divide-by-zero produces LO = all ones (and HI = dividend).
  localparam logic DS_ZERO_LO_FILL = 1'b1;

endpackage

// File: rtl/div_sequencer.sv
// EX-stage divide sequencer.
// Captures DIV/DIVU operands, drives the iterative divider, stalls EX while
// the divider works and holds the {HI,LO} result until the pipeline takes it.
// Also covers the divide-by-zero fast path, flush (annul) and a BUSY timeout.
//
// Handshake: result_o is valid in every cycle result_valid_o=1 (DONE state).
// The pipeline consumes it in any DONE cycle with ext_stall_i=0; while
// ext_stall_i=1 the result is held unchanged. The divider side is a level
// request: div_start_o stays high for the whole operation and the divider
// answers with a single-cycle div_ready_i carrying div_result_i.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 40,
  parameter int FAST_ZERO  = 1
) (
  input  logic                 clka,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  input  logic                 annul_i,
  input  logic                 ext_stall_i,
  input  logic                 div_ready_i,
  input  logic [2*WIDTH-1:0]   div_result_i,
  output logic                 div_start_o,
  output logic                 div_signed_o,
  output logic [WIDTH-1:0]     div_opa_o,
  output logic [WIDTH-1:0]     div_opb_o,
  output logic                 div_annul_o,
  output logic                 stall_div_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 result_valid_o,
  output logic                 timeout_o,
  output logic [1:0]           state_dbg
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);

  ds_state_t       state;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            zero_fast;

  // A new divide is taken only when its EX instruction is not being flushed.
  assign accept    = start_i & ~annul_i;
  assign zero_fast = (FAST_ZERO != 0) && (opb_i == '0);

  // The stall must rise in the start cycle itself so F/D/E freeze with it;
  // the zero fast path finishes without ever stalling.
  assign stall_div_o = ((state == DS_IDLE) & accept & ~zero_fast) |
                       (state == DS_BUSY);

  assign state_dbg = state;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clka) begin
    if (rst) begin
      state          <= DS_IDLE;
      cnt            <= '0;
      div_start_o    <= 1'b0;
      div_signed_o   <= 1'b0;
      div_opa_o      <= '0;
      div_opb_o      <= '0;
      div_annul_o    <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      div_annul_o <= 1'b0;
      timeout_o   <= 1'b0;
      case (state)
        DS_IDLE: begin
          if (accept) begin
            // Operands are frozen here; later forwarding changes are ignored.
            div_signed_o <= signed_i;
            div_opa_o    <= opa_i;
            div_opb_o    <= opb_i;
            cnt          <= '0;
            if (zero_fast) begin
              result_o       <= {opa_i, {WIDTH{DS_ZERO_LO_FILL}}};
              result_valid_o <= 1'b1;
              state          <= DS_DONE;
            end else begin
              div_start_o <= 1'b1;
              state       <= DS_BUSY;
            end
          end
        end
        DS_BUSY: begin
          cnt <= cnt + 1'b1;
          if (annul_i) begin
            // Flush wins over a same-cycle result: abort, no result.
            div_annul_o <= 1'b1;
            div_start_o <= 1'b0;
            state       <= DS_IDLE;
          end else if (div_ready_i) begin
            result_o       <= div_result_i;
            div_start_o    <= 1'b0;
            result_valid_o <= 1'b1;
            state          <= DS_DONE;
          end else if (cnt == CNT_LAST) begin
            // Divider never answered: abort it and hand back a zero result.
            timeout_o      <= 1'b1;
            div_annul_o    <= 1'b1;
            div_start_o    <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b1;
            state          <= DS_DONE;
          end
        end
        DS_DONE: begin
          if (annul_i || !ext_stall_i) begin
            result_valid_o <= 1'b0;
            state          <= DS_IDLE;
          end
        end
        default: begin
          div_start_o    <= 1'b0;
          result_valid_o <= 1'b0;
          state          <= DS_IDLE;
        end
      endcase
    end
  end

  // Losing start_i mid-divide without a flush means EX dropped its instruction.
  a_start_held: assert property (@(posedge clka) disable iff (rst)
    ((state == DS_BUSY) && !annul_i) |-> start_i);

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus randomized
// divides, a behavioural divider responder and a result scoreboard.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam int W    = 32;
  localparam int MAXC = 40;
  localparam int FZ   = 1;

  logic            clka = 1'b0;
  logic            rst;
  logic            start_i, signed_i, annul_i, ext_stall_i, div_ready_i;
  logic [W-1:0]    opa_i, opb_i;
  logic [2*W-1:0]  div_result_i;
  logic            div_start_o, div_signed_o, div_annul_o, stall_div_o;
  logic [W-1:0]    div_opa_o, div_opb_o;
  logic [2*W-1:0]  result_o;
  logic            result_valid_o, timeout_o;
  logic [1:0]      state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  int div_lat = 0;          // divider responder latency in BUSY cycles, 0 = never
  logic [2*W:0] exp_q[$];   // {timeout, rem, quot}

  div_sequencer #(.WIDTH(W), .MAX_CYCLES(MAXC), .FAST_ZERO(FZ)) dut (
    .clka(clka), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .opa_i(opa_i), .opb_i(opb_i), .annul_i(annul_i), .ext_stall_i(ext_stall_i),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_opa_o(div_opa_o), .div_opb_o(div_opb_o), .div_annul_o(div_annul_o),
    .stall_div_o(stall_div_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .timeout_o(timeout_o), .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  always #5 clka = ~clka;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference for the divide itself.
  function automatic logic [2*W-1:0] div_ref(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) return '1;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Expected {timeout, HI, LO} for one accepted divide.
  function automatic logic [2*W:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    logic [W-1:0] ones;
    ones = '1;
    if (FZ != 0 && b == '0) return {1'b0, a, ones};
    if (lat == 0 || lat > MAXC) return {1'b1, {(2*W){1'b0}}};
    return {1'b0, div_ref(sgn, a, b)};
  endfunction

  // Divider responder: answers after div_lat cycles of div_start_o.
  initial begin : divider
    int busy_cnt;
    busy_cnt = 0;
    div_ready_i = 1'b0;
    div_result_i = '0;
    forever begin
      @(posedge clka); #1;
      div_ready_i = 1'b0;
      if (div_start_o && !rst) begin
        busy_cnt++;
        if (div_lat != 0 && busy_cnt == div_lat) begin
          div_ready_i  = 1'b1;
          div_result_i = div_ref(div_signed_o, div_opa_o, div_opb_o);
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // Monitor: each new result presentation pops and checks one expectation.
  initial begin : monitor
    logic prev_valid;
    logic [2*W:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clka);
      if (!rst && result_valid_o && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got %0h with no expectation at %0t", result_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("result", {timeout_o, result_o}, e);
        end
      end
      prev_valid = rst ? 1'b0 : result_valid_o;
    end
  end

  // Driver: one divide entered and left at posedge+1.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input int annul_at, input int hold);
    logic zf;
    logic [2*W:0] e;
    int stalls, cyc, exp_stall;
    zf = (FZ != 0) && (b == '0);
    e = model(sgn, a, b, lat);
    div_lat = lat;
    start_i = 1'b1; signed_i = sgn; opa_i = a; opb_i = b;
    annul_i = 1'b0; ext_stall_i = (hold > 0);
    if (annul_at < 0) exp_q.push_back(e);
    @(negedge clka);
    check("issue_idle", state_dbg, DS_IDLE);
    check("issue_stall", stall_div_o, !zf);
    stalls = stall_div_o ? 1 : 0;
    if (!zf) begin
      @(posedge clka); #1;
      opa_i = $urandom; opb_i = $urandom;   // forwarding noise must be ignored
      @(negedge clka);
      check("busy_start", div_start_o, 1'b1);
      check("busy_signed", div_signed_o, sgn);
      check("busy_opa", div_opa_o, a);
      check("busy_opb", div_opb_o, b);
      stalls += stall_div_o ? 1 : 0;
    end
    if (annul_at >= 0) begin
      repeat (annul_at) @(posedge clka);
      #1;
      annul_i = 1'b1; start_i = 1'b0;
      @(posedge clka); #1;
      annul_i = 1'b0;
      @(negedge clka);
      check("annul_pulse", div_annul_o, 1'b1);
      check("annul_state", state_dbg, DS_IDLE);
      check("annul_start", div_start_o, 1'b0);
      check("annul_stall", stall_div_o, 1'b0);
      @(negedge clka);
      check("annul_once", div_annul_o, 1'b0);
      check("annul_novalid", result_valid_o, 1'b0);
      @(posedge clka); #1;
      return;
    end
    cyc = 0;
    forever begin
      @(negedge clka);
      cyc++;
      if (result_valid_o || cyc > 200) break;
      stalls += stall_div_o ? 1 : 0;
    end
    if (!result_valid_o) begin
      check("result_wait_timeout", 0, 1);
      @(posedge clka); #1;
      start_i = 1'b0; ext_stall_i = 1'b0;
      return;
    end
    exp_stall = zf ? 0 : 1 + ((lat == 0) ? MAXC : lat);
    check("stall_cycles", stalls, exp_stall);
    check("done_state", state_dbg, DS_DONE);
    check("done_stall", stall_div_o, 1'b0);
    check("done_start", div_start_o, 1'b0);
    check("done_abort", div_annul_o, e[2*W]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clka); #1;
      if (i == hold - 1) ext_stall_i = 1'b0;
      @(negedge clka);
      check("hold_valid", result_valid_o, 1'b1);
      check("hold_result", result_o, e[2*W-1:0]);
      check("hold_timeout", timeout_o, 1'b0);
    end
    @(posedge clka); #1;
    start_i = 1'b0; ext_stall_i = 1'b0;
  endtask

  // Reset in the middle of BUSY must clear everything without an abort pulse.
  task automatic run_reset_mid();
    div_lat = 0;
    start_i = 1'b1; signed_i = 1'b1; opa_i = 32'h1234_5678; opb_i = 32'd3;
    repeat (6) @(posedge clka);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clka); #1;
    rst = 1'b0;
    @(negedge clka);
    check("rst_state", state_dbg, DS_IDLE);
    check("rst_start", div_start_o, 1'b0);
    check("rst_annul", div_annul_o, 1'b0);
    check("rst_signed", div_signed_o, 1'b0);
    check("rst_ops", {div_opa_o, div_opb_o}, '0);
    check("rst_stall", stall_div_o, 1'b0);
    check("rst_result", {result_valid_o, timeout_o, result_o}, '0);
    @(posedge clka); #1;
  endtask

  // Stimulus sequence and final report.
  initial begin
    logic sgn;
    logic [W-1:0] a, b;
    int lat, an, hold;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; opa_i = '0; opb_i = '0;
    annul_i = 1'b0; ext_stall_i = 1'b0;
    repeat (3) @(posedge clka);
    @(negedge clka);
    check("reset_state", state_dbg, DS_IDLE);
    check("reset_outs", {div_start_o, div_signed_o, div_annul_o, stall_div_o,
                         result_valid_o, timeout_o}, '0);
    check("reset_data", {div_opa_o, div_opb_o, result_o}, '0);
    @(posedge clka); #1;
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 34, -1, 0);
    run_div(1'b1, -32'sd7, 32'd2, 12, -1, 0);
    run_div(1'b1, 32'd9, -32'sd4, 5, -1, 0);
    run_div(1'b1, 32'd5, 32'd0, 0, -1, 0);
    run_div(1'b0, 32'd5, 32'd0, 0, -1, 2);
    run_div(1'b0, 32'd1234, 32'd56, 20, 10, 0);
    run_div(1'b0, 32'd77, 32'd3, 0, -1, 0);
    run_div(1'b0, 32'd1000, 32'd9, 8, -1, 3);
    run_div(1'b1, 32'h8000_0000, 32'd1, 1, -1, 0);
    run_reset_mid();

    // A flushed start in IDLE is ignored and does not stall.
    start_i = 1'b1; annul_i = 1'b1; opb_i = 32'd4;
    @(negedge clka);
    check("idle_annul_stall", stall_div_o, 1'b0);
    @(posedge clka); #1;
    start_i = 1'b0; annul_i = 1'b0;
    @(negedge clka);
    check("idle_annul_state", state_dbg, DS_IDLE);
    @(posedge clka); #1;

    for (int n = 0; n < 30; n++) begin
      sgn = $urandom_range(0, 1);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? '0 : $urandom >> $urandom_range(0, 28);
      if (b == '0 && $urandom_range(0, 1) == 1) b = 32'd1;
      if (sgn && a == 32'h8000_0000 && b == '1) b = 32'd1;
      lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MAXC - 2);
      hold = $urandom_range(0, 2);
      an   = -1;
      if (b != '0 && lat >= 2 && $urandom_range(0, 5) == 0) an = $urandom_range(0, lat - 2);
      run_div(sgn, a, b, lat, an, hold);
    end

    repeat (4) @(posedge clka);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
